// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
// One outstanding request at a time; IAddr is held while IReq=1 until IAck.
interface fetch_unit_if;
  logic        IReq;
  logic [31:0] IAddr;
  logic        IAck;
  logic [31:0] IRData;

  modport master (output IReq, output IAddr, input IAck, input IRData);
  modport slave  (input IReq, input IAddr, output IAck, output IRData);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: fetch PC, small prefetch FIFO of {instr, pc+4},
// variable-latency imem request FSM, and branch redirect with stale-ack discard.
module fetch_unit #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         StallF,
  input  logic         PCSrcD,
  input  logic [31:0]  PCBranchD,
  fetch_unit_if.master imem,
  output logic [31:0]  InstrF,
  output logic [31:0]  PCPlus4F,
  output logic         InstrValidF
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DISCARD} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetchpc_q, fetchpc_d;
  logic [31:0]     iaddr_q, iaddr_d;
  logic            ireq_q, ireq_d;
  logic [CW-1:0]   count_q, count_next;
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [31:0]     instr_q [DEPTH];
  logic [31:0]     pc4_q   [DEPTH];
  logic            push, pop, space;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Head entry drives the D-stage outputs; an empty queue presents a NOP.
  assign InstrValidF = (count_q != '0);
  assign InstrF      = InstrValidF ? instr_q[rd_ptr_q] : '0;
  assign PCPlus4F    = InstrValidF ? pc4_q[rd_ptr_q]   : '0;

  assign imem.IReq  = ireq_q;
  assign imem.IAddr = iaddr_q;

  // A redirect kills both the pop and the push of its cycle.
  assign push       = imem.IAck && (state_q == BUSY) && !PCSrcD;
  assign pop        = InstrValidF && !StallF && !PCSrcD;
  assign count_next = count_q + CW'(push) - CW'(pop);
  // A new request is only launched when its slot is already guaranteed.
  assign space      = (count_next < CW'(DEPTH));

  // Next-state logic for the request FSM, fetch PC and request address.
  always_comb begin
    state_d   = state_q;
    fetchpc_d = fetchpc_q;
    iaddr_d   = iaddr_q;
    if (PCSrcD) begin
      fetchpc_d = PCBranchD;
      case (state_q)
        IDLE: begin
          iaddr_d = PCBranchD;
          state_d = BUSY;
        end
        BUSY, DISCARD: begin
          // An outstanding request is never withdrawn: without an ack we
          // park in DISCARD and eat the stale response later.
          if (imem.IAck) begin
            iaddr_d = PCBranchD;
            state_d = BUSY;
          end else begin
            state_d = DISCARD;
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      case (state_q)
        IDLE: begin
          if (space) begin
            iaddr_d = fetchpc_q;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (imem.IAck) begin
            fetchpc_d = iaddr_q + 32'd4;
            if (space) iaddr_d = iaddr_q + 32'd4;
            else       state_d = IDLE;
          end
        end
        DISCARD: begin
          if (imem.IAck) begin
            iaddr_d = fetchpc_q;
            state_d = BUSY;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    ireq_d = (state_d != IDLE);
  end

  // Control state and queue pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      fetchpc_q <= RESET_PC;
      iaddr_q   <= RESET_PC;
      ireq_q    <= 1'b0;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      fetchpc_q <= fetchpc_d;
      iaddr_q   <= iaddr_d;
      ireq_q    <= ireq_d;
      if (PCSrcD) begin
        count_q  <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        count_q <= count_next;
        if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
        if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
    end
  end

  // Queue storage; contents are qualified by count, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr_q] <= imem.IRData;
      pc4_q[wr_ptr_q]   <= iaddr_q + 32'd4;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written multi-cycle
// sequences and randomized traffic checked against an in-order fetch model.
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        StallF = 1'b0;
  logic        PCSrcD = 1'b0;
  logic [31:0] PCBranchD = '0;
  logic [31:0] InstrF, PCPlus4F;
  logic        InstrValidF;

  fetch_unit_if imem();

  fetch_unit #(.DEPTH(2), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .StallF(StallF), .PCSrcD(PCSrcD),
    .PCBranchD(PCBranchD), .imem(imem), .InstrF(InstrF),
    .PCPlus4F(PCPlus4F), .InstrValidF(InstrValidF)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Memory contents: a tag ORed onto the address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a | 32'hA000_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Memory responder: acks a pending request after cur_dly idle cycles.
  int dly = 0;
  int dmax = 0;
  bit rnd = 1'b0;
  int wcnt = 0;
  int cur_dly = 0;
  always @(negedge clk) begin
    if (!reset || !imem.IReq) begin
      imem.IAck   = 1'b0;
      imem.IRData = 32'hDEAD_BEEF;
      wcnt        = 0;
      cur_dly     = rnd ? int'($urandom_range(dmax, 0)) : dly;
    end else if (wcnt >= cur_dly) begin
      imem.IAck   = 1'b1;
      imem.IRData = mem(imem.IAddr);
      wcnt        = 0;
      cur_dly     = rnd ? int'($urandom_range(dmax, 0)) : dly;
    end else begin
      imem.IAck   = 1'b0;
      imem.IRData = 32'hDEAD_BEEF;
      wcnt++;
    end
  end

  // Reference model: the D stage must consume a gap-free sequential address
  // stream starting at RESET_PC, restarting at each branch target.
  logic [31:0] exp_pc = RST_PC;
  int npop = 0;

  // One clock: check the presented head before the edge, bus hold after it.
  task automatic step();
    logic pre_rq, pre_ack;
    logic [31:0] pre_ad;
    @(negedge clk); #1;
    pre_rq = imem.IReq; pre_ack = imem.IAck; pre_ad = imem.IAddr;
    if (!InstrValidF) begin
      chk("empty_instr", InstrF, 32'h0);
      chk("empty_pc4", PCPlus4F, 32'h0);
    end else if (!StallF && !PCSrcD) begin
      chk("pop_instr", InstrF, mem(exp_pc));
      chk("pop_pc4", PCPlus4F, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
      npop++;
    end
    if (PCSrcD) exp_pc = PCBranchD;
    @(posedge clk); #1;
    if (pre_rq && !pre_ack) begin
      chk("hold_req", {31'b0, imem.IReq}, 32'h1);
      chk("hold_addr", imem.IAddr, pre_ad);
    end
  endtask

  // Leaves reset released at posedge+2, so the next edge is the first one.
  task automatic do_reset();
    StallF = 1'b0; PCSrcD = 1'b0; PCBranchD = '0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    exp_pc = RST_PC;
  endtask

  typedef struct packed {
    logic        st;
    logic        br;
    logic [31:0] tgt;
    logic        v;
    logic [31:0] ins;
    logic [31:0] p4;
    logic        rq;
    logic [31:0] ad;
  } vec_t;
  vec_t tbl [15];

  initial begin
    bit found;
    // Zero-wait memory: fill under stall, drain, redirect on an ack, wrap.
    tbl[0]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b1, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'hA000_0000, 32'h4,       1'b1, 32'h4};
    tbl[2]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'hA000_0000, 32'h4,       1'b0, 32'h4};
    tbl[3]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'hA000_0000, 32'h4,       1'b0, 32'h4};
    tbl[4]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hA000_0004, 32'h8,       1'b1, 32'h8};
    tbl[5]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hA000_0008, 32'hC,       1'b1, 32'hC};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hA000_000C, 32'h10,      1'b1, 32'h10};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hA000_0010, 32'h14,      1'b1, 32'h14};
    tbl[8]  = '{1'b0, 1'b1, 32'h40,       1'b0, 32'h0,        32'h0,        1'b1, 32'h40};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hA000_0040, 32'h44,      1'b1, 32'h44};
    tbl[10] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hA000_0044, 32'h48,      1'b1, 32'h48};
    tbl[11] = '{1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0,        32'h0,        1'b1, 32'hFFFF_FFF8};
    tbl[12] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC};
    tbl[13] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFFC, 32'h0,       1'b1, 32'h0};
    tbl[14] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hA000_0000, 32'h4,       1'b1, 32'h4};

    // Reset values while reset is held.
    rnd = 1'b0; dly = 0;
    #2;
    chk("rst_ireq", {31'b0, imem.IReq}, 32'h0);
    chk("rst_iaddr", imem.IAddr, RST_PC);
    chk("rst_valid", {31'b0, InstrValidF}, 32'h0);
    chk("rst_instr", InstrF, 32'h0);

    do_reset();
    for (int i = 0; i < 15; i++) begin
      StallF = tbl[i].st; PCSrcD = tbl[i].br; PCBranchD = tbl[i].tgt;
      step();
      chk($sformatf("t%0d_valid", i), {31'b0, InstrValidF}, {31'b0, tbl[i].v});
      chk($sformatf("t%0d_instr", i), InstrF, tbl[i].ins);
      chk($sformatf("t%0d_pc4", i), PCPlus4F, tbl[i].p4);
      chk($sformatf("t%0d_ireq", i), {31'b0, imem.IReq}, {31'b0, tbl[i].rq});
      chk($sformatf("t%0d_iaddr", i), imem.IAddr, tbl[i].ad);
    end
    PCSrcD = 1'b0;

    // Redirect while a slow request to 0x8 is outstanding.
    dly = 3;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (imem.IReq && imem.IAddr == 32'h8) found = 1'b1;
      else step();
    end
    chk("slow_reach8", {31'b0, found}, 32'h1);
    PCSrcD = 1'b1; PCBranchD = 32'h100;
    step();
    PCSrcD = 1'b0;
    chk("slow_hold8", imem.IAddr, 32'h8);
    chk("slow_valid0", {31'b0, InstrValidF}, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (imem.IAddr == 32'h100) found = 1'b1;
      else chk("slow_no_data", {31'b0, InstrValidF}, 32'h0);
    end
    chk("slow_addr100", {31'b0, found}, 32'h1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (InstrValidF) found = 1'b1;
      else step();
    end
    chk("slow_instr", InstrF, 32'hA000_0100);
    chk("slow_pc4", PCPlus4F, 32'h104);

    // Each ack delayed 4 cycles: NOP gaps between deliveries.
    dly = 4;
    do_reset();
    npop = 0;
    for (int i = 0; i < 60; i++) step();
    chk("gap_progress", {31'b0, (npop >= 8)}, 32'h1);
    chk("gap_seq", exp_pc, RST_PC + 32'(npop * 4));

    // Asynchronous reset with a request outstanding and a non-empty queue.
    dly = 3;
    do_reset();
    StallF = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (InstrValidF && imem.IReq) found = 1'b1;
      else step();
    end
    chk("arst_setup", {31'b0, found}, 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("arst_ireq", {31'b0, imem.IReq}, 32'h0);
    chk("arst_iaddr", imem.IAddr, RST_PC);
    chk("arst_valid", {31'b0, InstrValidF}, 32'h0);
    chk("arst_instr", InstrF, 32'h0);
    chk("arst_pc4", PCPlus4F, 32'h0);
    @(posedge clk);
    #2 reset = 1'b1;
    StallF = 1'b0;
    exp_pc = RST_PC;
    step();
    chk("arst_refetch_req", {31'b0, imem.IReq}, 32'h1);
    chk("arst_refetch_addr", imem.IAddr, RST_PC);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (InstrValidF) found = 1'b1;
      else step();
    end
    chk("arst_first_instr", InstrF, mem(RST_PC));

    // Random stalls, redirects and memory latency against the model.
    rnd = 1'b1; dmax = 3;
    do_reset();
    npop = 0;
    for (int i = 0; i < 600; i++) begin
      StallF = ($urandom_range(2, 0) == 0);
      PCSrcD = ($urandom_range(11, 0) == 0);
      if ($urandom_range(3, 0) == 0) PCBranchD = 32'hFFFF_FFF0;
      else PCBranchD = $urandom() & 32'h0000_FFFC;
      step();
    end
    PCSrcD = 1'b0;
    chk("rnd_progress", {31'b0, (npop > 50)}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute guard so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
